// File: rtl/cmp_pkg.sv
// Shared compare-op encodings for the branch evaluator and the D-stage decoder.
package cmp_pkg;

    localparam int CMP_OP_W = 3;

    typedef enum logic [CMP_OP_W-1:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LEZ = 3'd2,
        CMP_GTZ = 3'd3,
        CMP_LTZ = 3'd4,
        CMP_GEZ = 3'd5,
        CMP_LT  = 3'd6,
        CMP_LTU = 3'd7
    } cmp_op_t;

endpackage

// File: rtl/cmp_core.sv
// Purely combinational branch-condition evaluator: one of eight compares on two WIDTH-bit operands.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  cmp_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             taken
);

    logic a_neg;
    logic a_zero;

    assign a_neg  = a[WIDTH-1];
    assign a_zero = (a == '0);

    // Zero-compare ops look only at the sign bit and the all-zero test of a.
    always_comb begin
        taken = 1'b0;
        unique case (op)
            CMP_EQ:  taken = (a == b);
            CMP_NE:  taken = (a != b);
            CMP_LEZ: taken = a_neg | a_zero;
            CMP_GTZ: taken = !a_neg && !a_zero;
            CMP_LTZ: taken = a_neg;
            CMP_GEZ: taken = !a_neg;
            CMP_LT:  taken = ($signed(a) < $signed(b));
            CMP_LTU: taken = (a < b);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cmp_pipe.sv
// Registered branch-condition unit with valid/ready handshake, flush and tag passthrough.
// Define CMP_STATS_EN to build saturating evaluated/taken counters; otherwise they read 0.
module cmp_pipe
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  cmp_op_t          in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] stat_eval,
    output logic [CNT_W-1:0] stat_taken
);

    logic core_taken;
    logic push;
    logic pop;

    cmp_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .op    (in_op),
        .a     (in_a),
        .b     (in_b),
        .taken (core_taken)
    );

    assign in_ready = !out_valid || out_ready;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = out_valid && out_ready;

    // Single output slot: flush beats push, and a push reloads the slot even while it is being popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_taken <= 1'b0;
            out_tag   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (push) begin
            out_valid <= 1'b1;
            out_taken <= core_taken;
            out_tag   <= in_tag;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

`ifdef CMP_STATS_EN
    // A pop counts as accepted even when flush is asserted in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_eval  <= '0;
            stat_taken <= '0;
        end else if (pop) begin
            if (stat_eval != '1) begin
                stat_eval <= stat_eval + CNT_W'(1);
            end
            if (out_taken && (stat_taken != '1)) begin
                stat_taken <= stat_taken + CNT_W'(1);
            end
        end
    end
`else
    assign stat_eval  = '0;
    assign stat_taken = '0;
`endif

endmodule
